// File: rtl/counter_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// counter_ctrl_pkg
// Shared types and constants for the counter_ctrl block:
//   state_e       : controller states IDLE / RUN / PAUSE / DONE
//   op_e          : command opcodes carried on cmd_op
//   DEFAULT_WIDTH : default counter / terminal-value width
// -----------------------------------------------------------------------------
package counter_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_START = 2'b01,
        OP_STOP  = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

endpackage : counter_ctrl_pkg

// File: rtl/counter_ctrl_if.sv
// -----------------------------------------------------------------------------
// counter_ctrl_if
// Command channel between a host/sequencer and counter_ctrl.
//   cmd_valid   : command present                  (master -> slave)
//   cmd_ready   : controller can accept a command  (slave  -> master)
//   cmd_op      : opcode, see op_e                 (master -> slave)
//   cmd_data    : terminal value for LOAD          (master -> slave)
//   mode_reload : 1 = auto-reload, 0 = one-shot; used when START is accepted
// Modports: master (host side), slave (controller side).
// -----------------------------------------------------------------------------
interface counter_ctrl_if
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             cmd_valid;
    logic             cmd_ready;
    op_e              cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic             mode_reload;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_data,
        output mode_reload,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_data,
        input  mode_reload,
        output cmd_ready
    );

endinterface : counter_ctrl_if

// File: rtl/counter_core.sv
// -----------------------------------------------------------------------------
// counter_core
// WIDTH-bit unsigned up-counter with synchronous clear.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset, count -> 0
//   clr   : synchronous clear, wins over inc
//   inc   : increment by one
//   count : registered count value
// -----------------------------------------------------------------------------
module counter_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    // NOTE: reset is sampled only at the clock edge, so it belongs inside the
    // posedge-only always_ff; state registers use <= so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (inc) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule : counter_core

// File: rtl/counter_ctrl.sv
// -----------------------------------------------------------------------------
// counter_ctrl
// Command-driven sequencer for a WIDTH-bit up-counter: LOAD a terminal value,
// START / STOP (pause) / resume, CLEAR; one-shot or auto-reload operation and a
// terminal-count pulse.
//   clk       : rising-edge clock
//   rst_n     : synchronous active-low reset
//   cmd       : counter_ctrl_if.slave command channel (valid/ready/op/data/mode)
//   count_out : registered count
//   busy      : high in RUN
//   tc_pulse  : high in RUN while count_out == terminal value
//   done      : high in DONE (one-shot run finished)
// Optional build macro COUNTER_CTRL_PRESCALE_EN: the count only advances in RUN
// on cycles where an internal prescaler reaches PRESCALE-1. Without it the
// count advances every RUN cycle and PRESCALE has no effect.
// -----------------------------------------------------------------------------
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int PRESCALE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    counter_ctrl_if.slave    cmd,
    output logic [WIDTH-1:0] count_out,
    output logic             busy,
    output logic             tc_pulse,
    output logic             done
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] term_q, term_d;
    logic             mode_q, mode_d;
    logic             ready_q;

    logic             accept;
    logic             cmd_eff;   // accepted command that actually changes something
    logic             run_go;    // RUN cycle not overridden by a command
    logic             step;      // count may advance this cycle
    logic             at_term;
    logic             cnt_clr;
    logic             cnt_inc;

    assign accept        = cmd.cmd_valid && ready_q;
    assign cmd.cmd_ready = ready_q;
    assign at_term       = (count_out == term_q);

    // START while running and STOP outside RUN are no-ops, so they must not
    // suppress the normal RUN behaviour of that cycle.
    assign cmd_eff = accept &&
                     ((cmd.cmd_op == OP_LOAD)  ||
                      (cmd.cmd_op == OP_CLEAR) ||
                      ((cmd.cmd_op == OP_START) && (state_q != RUN)) ||
                      ((cmd.cmd_op == OP_STOP)  && (state_q == RUN)));

    assign run_go = (state_q == RUN) && !cmd_eff;

`ifdef COUNTER_CTRL_PRESCALE_EN
    localparam int PSC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);

    logic [PSC_W-1:0] psc_q, psc_d;
    logic             psc_clr;

    // Every effective command except STOP restarts the prescale period; STOP
    // (entering PAUSE) leaves it frozen where it was.
    assign psc_clr = cmd_eff && (cmd.cmd_op != OP_STOP);
    assign step    = (psc_q == PSC_LAST);

    always_comb begin
        psc_d = psc_q;
        if (psc_clr) begin
            psc_d = '0;
        end else if (run_go) begin
            psc_d = step ? '0 : psc_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            psc_q <= '0;
        end else begin
            psc_q <= psc_d;
        end
    end
`else
    assign step = 1'b1;
`endif

    // NOTE: every output of this block gets a default before any branch, so
    // no path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        term_d  = term_q;
        mode_d  = mode_q;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;

        if (accept) begin
            case (cmd.cmd_op)
                OP_LOAD: begin
                    term_d  = cmd.cmd_data;
                    cnt_clr = 1'b1;
                    state_d = IDLE;
                end
                OP_START: begin
                    if (state_q == PAUSE) begin
                        state_d = RUN;
                    end else if (state_q != RUN) begin
                        cnt_clr = 1'b1;
                        mode_d  = cmd.mode_reload;
                        state_d = RUN;
                    end
                end
                OP_STOP: begin
                    if (state_q == RUN) begin
                        state_d = PAUSE;
                    end
                end
                OP_CLEAR: begin
                    cnt_clr = 1'b1;
                    state_d = IDLE;
                end
                default: ;
            endcase
        end

        if (run_go && step) begin
            if (at_term) begin
                if (mode_q) begin
                    cnt_clr = 1'b1;
                end else begin
                    state_d = DONE;
                end
            end else begin
                cnt_inc = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            term_q  <= '1;
            mode_q  <= 1'b1;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            term_q  <= term_d;
            mode_q  <= mode_d;
            // Drops for exactly one cycle after each acceptance.
            ready_q <= !accept;
        end
    end

    counter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .count (count_out)
    );

    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign tc_pulse = busy && at_term;

endmodule : counter_ctrl

// File: tb/tb_counter_ctrl.sv
// -----------------------------------------------------------------------------
// tb_counter_ctrl
// Self-checking bench for counter_ctrl in its default build (no prescaler).
// A behavioural model tracks phase / count / terminal / mode / ready with plain
// integer arithmetic; every cycle the DUT outputs are compared with it, and the
// directed scenarios add checks against literal expected values.
// -----------------------------------------------------------------------------
module tb_counter_ctrl;
    import counter_ctrl_pkg::*;

    localparam int W    = 4;
    localparam int MAXV = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] count_out;
    logic         busy;
    logic         tc_pulse;
    logic         done;

    always #5 clk = ~clk;

    counter_ctrl_if #(.WIDTH(W)) cmd_if ();

    counter_ctrl #(
        .WIDTH    (W),
        .PRESCALE (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd       (cmd_if),
        .count_out (count_out),
        .busy      (busy),
        .tc_pulse  (tc_pulse),
        .done      (done)
    );

    // ---------------- reference model ----------------
    typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_DONE} mphase_e;

    mphase_e m_ph;
    int      m_cnt;
    int      m_term;
    bit      m_reload;
    bit      m_ready;

    int errors = 0;
    int checks = 0;

    task automatic model_reset();
        m_ph     = M_IDLE;
        m_cnt    = 0;
        m_term   = MAXV;
        m_reload = 1'b1;
        m_ready  = 1'b1;
    endtask

    // Applies one rising edge to the model using the inputs currently driven.
    task automatic model_edge();
        bit acc;
        bit took;
        if (!rst_n) begin
            model_reset();
            return;
        end
        acc     = cmd_if.cmd_valid && m_ready;
        m_ready = !acc;
        took    = 1'b0;
        if (acc) begin
            case (cmd_if.cmd_op)
                OP_LOAD: begin
                    m_term = int'(cmd_if.cmd_data);
                    m_cnt  = 0;
                    m_ph   = M_IDLE;
                    took   = 1'b1;
                end
                OP_START: begin
                    if (m_ph == M_PAUSE) begin
                        m_ph = M_RUN;
                        took = 1'b1;
                    end else if (m_ph == M_IDLE || m_ph == M_DONE) begin
                        m_cnt    = 0;
                        m_reload = cmd_if.mode_reload;
                        m_ph     = M_RUN;
                        took     = 1'b1;
                    end
                end
                OP_STOP: begin
                    if (m_ph == M_RUN) begin
                        m_ph = M_PAUSE;
                        took = 1'b1;
                    end
                end
                default: begin
                    m_cnt = 0;
                    m_ph  = M_IDLE;
                    took  = 1'b1;
                end
            endcase
        end
        if (!took && m_ph == M_RUN) begin
            if (m_cnt == m_term) begin
                if (m_reload) m_cnt = 0;
                else          m_ph  = M_DONE;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic compare_all();
        check("model.count", 32'(count_out), 32'(m_cnt));
        check("model.ready", 32'(cmd_if.cmd_ready), 32'(m_ready));
        check("model.busy",  32'(busy), 32'(m_ph == M_RUN));
        check("model.done",  32'(done), 32'(m_ph == M_DONE));
        check("model.tc",    32'(tc_pulse), 32'(m_ph == M_RUN && m_cnt == m_term));
    endtask

    // One clock: model and DUT see the same edge, outputs sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic send(input op_e op, input int data, input bit mode);
        while (!m_ready) tick();
        cmd_if.cmd_valid   = 1'b1;
        cmd_if.cmd_op      = op;
        cmd_if.cmd_data    = W'(data);
        cmd_if.mode_reload = mode;
        tick();
        cmd_if.cmd_valid   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        cmd_if.cmd_valid   = 1'b0;
        cmd_if.cmd_op      = OP_LOAD;
        cmd_if.cmd_data    = '0;
        cmd_if.mode_reload = 1'b1;
        model_reset();

        // Reset state
        rst_n = 1'b0;
        tick();
        tick();
        check("rst.count", 32'(count_out), 0);
        check("rst.ready", 32'(cmd_if.cmd_ready), 1);
        check("rst.busy",  32'(busy), 0);
        check("rst.done",  32'(done), 0);
        check("rst.tc",    32'(tc_pulse), 0);
        rst_n = 1'b1;
        tick();

        // Free-running wrap with default terminal 15, then reset mid-run
        send(OP_START, 0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            check("wrap.count", 32'(count_out), 32'(i % 16));
            check("wrap.tc",    32'(tc_pulse), 32'((i % 16) == 15));
            tick();
        end
        rst_n = 1'b0;
        tick();
        check("midrst.count", 32'(count_out), 0);
        check("midrst.busy",  32'(busy), 0);
        check("midrst.ready", 32'(cmd_if.cmd_ready), 1);
        rst_n = 1'b1;
        tick();

        // One-shot to 5
        send(OP_LOAD, 5, 1'b0);
        send(OP_START, 0, 1'b0);
        for (int i = 0; i <= 5; i++) begin
            check("oneshot.count", 32'(count_out), 32'(i));
            check("oneshot.tc",    32'(tc_pulse), 32'(i == 5));
            check("oneshot.busy",  32'(busy), 1);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            check("oneshot.done",      32'(done), 1);
            check("oneshot.idle_busy", 32'(busy), 0);
            check("oneshot.hold",      32'(count_out), 5);
            tick();
        end
        send(OP_START, 0, 1'b0);
        check("restart.count", 32'(count_out), 0);
        check("restart.busy",  32'(busy), 1);

        // Pause at 4 and resume
        send(OP_LOAD, 9, 1'b1);
        send(OP_START, 0, 1'b1);
        repeat (4) tick();
        check("pause.pre", 32'(count_out), 4);
        send(OP_STOP, 0, 1'b0);
        check("pause.busy", 32'(busy), 0);
        for (int i = 0; i < 10; i++) begin
            check("pause.hold", 32'(count_out), 4);
            tick();
        end
        send(OP_START, 0, 1'b0);
        check("resume.held", 32'(count_out), 4);
        tick();
        check("resume.5", 32'(count_out), 5);
        tick();
        check("resume.6", 32'(count_out), 6);

        // Back-to-back commands with valid held; ignored STOP in IDLE, START in RUN
        send(OP_CLEAR, 0, 1'b0);
        while (!m_ready) tick();
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = OP_STOP;
        tick();
        check("b2b.stop_idle_busy", 32'(busy), 0);
        check("b2b.gap_ready",      32'(cmd_if.cmd_ready), 0);
        cmd_if.cmd_op      = OP_START;
        cmd_if.mode_reload = 1'b1;
        tick();
        check("b2b.not_taken_busy", 32'(busy), 0);
        check("b2b.ready_back",     32'(cmd_if.cmd_ready), 1);
        tick();
        check("b2b.start_busy",  32'(busy), 1);
        check("b2b.start_count", 32'(count_out), 0);
        tick();
        check("b2b.run1", 32'(count_out), 1);
        tick();
        check("b2b.start_in_run", 32'(count_out), 2);
        check("b2b.still_busy",   32'(busy), 1);
        cmd_if.cmd_valid = 1'b0;

        // STOP on the terminal cycle
        send(OP_LOAD, 3, 1'b1);
        send(OP_START, 0, 1'b1);
        repeat (3) tick();
        check("tstop.count", 32'(count_out), 3);
        check("tstop.tc",    32'(tc_pulse), 1);
        send(OP_STOP, 0, 1'b0);
        check("tstop.paused", 32'(count_out), 3);
        check("tstop.no_tc",  32'(tc_pulse), 0);
        send(OP_START, 0, 1'b0);
        check("tstop.resume_tc", 32'(tc_pulse), 1);
        tick();
        check("tstop.reload", 32'(count_out), 0);

        // Randomized traffic against the model
        for (int n = 0; n < 800; n++) begin
            rst_n              = ($urandom_range(0, 63) != 0);
            cmd_if.cmd_valid   = ($urandom_range(0, 3) == 0);
            cmd_if.cmd_op      = op_e'(2'($urandom_range(0, 3)));
            cmd_if.cmd_data    = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, MAXV))
                                                               : W'($urandom_range(0, 4));
            cmd_if.mode_reload = 1'($urandom_range(0, 1));
            tick();
        end
        cmd_if.cmd_valid = 1'b0;
        rst_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_counter_ctrl
